// File: rtl/demux_sched_if.sv
// demux_sched_if: input stream, destination control and held-output bundle
// for the 1-to-4 stream scheduler.
`default_nettype none

interface demux_sched_if #(
  parameter int W = 8
);
  logic         d_valid;
  logic [W-1:0] d;
  logic         d_ready;
  logic [3:0]   dst_en;
  logic [3:0]   dst_ready;
  logic [W-1:0] y;
  logic [3:0]   y_valid;
  logic [1:0]   s;

  modport master (
    output d_valid, d, dst_en, dst_ready,
    input  d_ready, y, y_valid, s
  );

  modport slave (
    input  d_valid, d, dst_en, dst_ready,
    output d_ready, y, y_valid, s
  );
endinterface

`default_nettype wire

// File: rtl/demux_sched.sv
// ============================================================================
//  Module     : demux_sched
//  Description: Registered 1-to-4 round-robin burst scheduler with a one-word
//               output buffer. Optional per-destination accept counters are
//               enabled by defining DEMUX_SCHED_STATS_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_sched #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
`ifdef DEMUX_SCHED_STATS_EN
  input  wire logic [1:0]  stat_sel,
  output logic      [15:0] stat_cnt,
`endif
  demux_sched_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t       state_q;
  logic [W-1:0] y_q;
  logic [3:0]   y_valid_q;
  logic [1:0]   s_q;
  logic [3:0]   bc_q;

  logic         acc;
  logic         d_ready;
  logic         ld;
  logic         cont;
  logic [1:0]   tgt;
  logic [3:0]   bc_d;

  // First enabled index in the order cur+1, cur+2, cur+3, cur.
  function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    for (int k = 4; k >= 1; k--) begin
      c = cur + 2'(k);
      if (en[c]) r = c;
    end
    return r;
  endfunction

  always_comb begin
    acc     = |(y_valid_q & bus.dst_ready);
    d_ready = (bus.dst_en != 4'b0000) && ((state_q == ST_EMPTY) || acc);
    ld      = bus.d_valid & d_ready;
    cont    = bus.dst_en[s_q] && (bc_q != 4'(BURST));
    tgt     = cont ? s_q : rr_next(s_q, bus.dst_en);
    bc_d    = cont ? (bc_q + 4'd1) : 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      y_q       <= '0;
      y_valid_q <= 4'b0000;
      s_q       <= 2'd0;
      bc_q      <= 4'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (ld) begin
            y_q       <= bus.d;
            y_valid_q <= 4'b0001 << tgt;
            s_q       <= tgt;
            bc_q      <= bc_d;
            state_q   <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A load here always coincides with acceptance of the held word.
          if (ld) begin
            y_q       <= bus.d;
            y_valid_q <= 4'b0001 << tgt;
            s_q       <= tgt;
            bc_q      <= bc_d;
          end else if (acc) begin
            y_valid_q <= 4'b0000;
            state_q   <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.d_ready = d_ready;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.s       = s_q;

`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] cnt_q [4];

  // While FULL the single y_valid bit always equals s_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 16'd0;
    end else if (acc) begin
      cnt_q[s_q] <= cnt_q[s_q] + 16'd1;
    end
  end

  assign stat_cnt = cnt_q[stat_sel];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_sched.sv
// tb_demux_sched: table vectors, directed corner sequences and randomized
// traffic checked against a queue-level scheduling model.
`default_nettype none

module tb_demux_sched;
  localparam int W     = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_sched_if #(.W(W)) bus ();

`ifdef DEMUX_SCHED_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;
`endif

  demux_sched #(.W(W), .BURST(BURST)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DEMUX_SCHED_STATS_EN
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: holding slot, rotation pointer, words sent in burst.
  bit       m_full;
  bit [7:0] m_y;
  int       m_dst;
  int       m_ptr;
  int       m_sent;
  int       m_cnt [4];

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic [3:0] en;
    logic [3:0] rdy;
    logic [7:0] ey;
    logic [3:0] eyv;
    logic       edr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_dr(input logic [3:0] en, input logic [3:0] rdy);
    bit acc;
    acc = m_full && rdy[m_dst];
    return (en != 4'b0) && (!m_full || acc);
  endfunction

  task automatic model_reset();
    m_full = 0; m_y = 0; m_dst = 0; m_ptr = 0; m_sent = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic r, input logic dv, input logic [7:0] dd,
                            input logic [3:0] en, input logic [3:0] rdy);
    bit acc, ld;
    int t;
    if (r) begin
      model_reset();
      return;
    end
    acc = m_full && rdy[m_dst];
    ld  = dv && model_dr(en, rdy);
    if (acc) m_cnt[m_dst] = (m_cnt[m_dst] + 1) % 65536;
    if (ld) begin
      if (en[m_ptr] && m_sent != BURST) begin
        t = m_ptr;
        m_sent = m_sent + 1;
      end else begin
        t = m_ptr;
        for (int k = 1; k <= 4; k++) begin
          if (en[(m_ptr + k) % 4]) begin
            t = (m_ptr + k) % 4;
            break;
          end
        end
        m_sent = 1;
      end
      m_y = dd; m_dst = t; m_ptr = t; m_full = 1;
    end else if (acc) begin
      m_full = 0;
    end
  endtask

  // One clock: drive, check against the model before the edge, then advance.
  task automatic step(input logic r, input logic dv, input logic [7:0] dd,
                      input logic [3:0] en, input logic [3:0] rdy);
    rst = r; bus.d_valid = dv; bus.d = dd; bus.dst_en = en; bus.dst_ready = rdy;
    #1;
    chk("d_ready", 32'(bus.d_ready), 32'(model_dr(en, rdy)));
    chk("y", 32'(bus.y), 32'(m_y));
    chk("y_valid", 32'(bus.y_valid), m_full ? (32'd1 << m_dst) : 32'd0);
    chk("s", 32'(bus.s), 32'(m_ptr));
`ifdef DEMUX_SCHED_STATS_EN
    stat_sel = 2'($urandom_range(0, 3));
    #1;
    chk("stat_cnt", 32'(stat_cnt), 32'(m_cnt[stat_sel]));
`endif
    @(posedge clk);
    model_edge(r, dv, dd, en, rdy);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 4'hF, 4'hF);
    chk("reset_y_valid", 32'(bus.y_valid), 32'd0);
    chk("reset_s", 32'(bus.s), 32'd0);
    chk("reset_y", 32'(bus.y), 32'd0);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      rst = 1'b0; bus.d_valid = tbl[i].dv; bus.d = tbl[i].d;
      bus.dst_en = tbl[i].en; bus.dst_ready = tbl[i].rdy;
      #1;
      chk("tbl_d_ready", 32'(bus.d_ready), 32'(tbl[i].edr));
      step(1'b0, tbl[i].dv, tbl[i].d, tbl[i].en, tbl[i].rdy);
      chk("tbl_y", 32'(bus.y), 32'(tbl[i].ey));
      chk("tbl_y_valid", 32'(bus.y_valid), 32'(tbl[i].eyv));
    end
    tbl.delete();
  endtask

  initial begin
    logic [3:0] rdy1_low;
    rdy1_low = 4'b1101;
    rst = 1'b1; bus.d_valid = 1'b0; bus.d = '0; bus.dst_en = 4'hF; bus.dst_ready = 4'hF;
`ifdef DEMUX_SCHED_STATS_EN
    stat_sel = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Round-robin without stall: 4 words per destination, y one cycle behind d.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, 8'(i), 4'b1111, 4'b1111, 8'(i), 4'b0001 << (i / 4), 1'b1});
    run_table();
    step(1'b0, 1'b0, 8'h00, 4'hF, 4'hF);
`ifdef DEMUX_SCHED_STATS_EN
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      #1;
      chk("stats_after_rr", 32'(stat_cnt), 32'd4);
    end
`endif

    // Masked destination 2: order 0,1,3.
    do_reset();
    for (int i = 0; i < 12; i++)
      tbl.push_back('{1'b1, 8'(8'h20 + i), 4'b1011, 4'b1111, 8'(8'h20 + i),
                      (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b1000, 1'b1});
    run_table();
`ifdef DEMUX_SCHED_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stat_sel = 2'(i);
      #1;
      chk("stats_after_rst", 32'(stat_cnt), 32'd0);
    end
`endif

    // Back-pressure: hold 0x04 on destination 1 for 5 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 4'hF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h05, 4'hF, rdy1_low);
      chk("bp_y", 32'(bus.y), 32'h04);
      chk("bp_y_valid", 32'(bus.y_valid), 32'b0010);
      chk("bp_d_ready", 32'(bus.d_ready), 32'd0);
    end
    step(1'b0, 1'b1, 8'h05, 4'hF, 4'hF);
    chk("bp_release_y", 32'(bus.y), 32'h05);
    chk("bp_release_y_valid", 32'(bus.y_valid), 32'b0010);

    // Mask change while holding a word on destination 0.
    do_reset();
    step(1'b0, 1'b1, 8'hA0, 4'hF, 4'h0);
    step(1'b0, 1'b0, 8'h00, 4'b1110, 4'h0);
    step(1'b0, 1'b0, 8'h00, 4'b1110, 4'h0);
    chk("mask_hold_y_valid", 32'(bus.y_valid), 32'b0001);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + i), 4'b1110, 4'hF);
      chk("mask_next_y_valid", 32'(bus.y_valid), (i <= 4) ? 32'b0010 : 32'b0100);
    end

    // All masked: no loads, held word drains.
    bus.dst_en = 4'h0; bus.d_valid = 1'b1; bus.dst_ready = 4'hF;
    #1;
    chk("all_masked_d_ready", 32'(bus.d_ready), 32'd0);
    step(1'b0, 1'b1, 8'h77, 4'h0, 4'hF);
    chk("all_masked_drain", 32'(bus.y_valid), 32'd0);
    step(1'b0, 1'b1, 8'h78, 4'h0, 4'hF);
    chk("all_masked_noload", 32'(bus.y_valid), 32'd0);

    // Reset while FULL on a non-zero destination.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 4'hF, 4'hF);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : (($urandom_range(0, 15) == 0) ? 4'h0 : 4'hF),
           ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
